// File: rtl/regfile_dump_sequencer.sv
// Purpose: drives the debug read-mux select and streams register contents (one or all 32) out a valid/ready port.
// Latency: accepted start -> select driven next cycle -> beat valid the cycle after; full dump with ready high = 64 cycles (62 skipping x0).
// Backpressure: a held beat keeps addr/data/select stable until out_ready; at most one beat per two cycles, no internal buffering.
module regfile_dump_sequencer #(
    parameter int WIDTH     = 32,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dump_all,
    input  logic [4:0]       addr,
    input  logic             abort,
    output logic [4:0]       rf_sel,
    input  logic [WIDTH-1:0] rf_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_addr,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] FIRST_IDX = SKIP_ZERO ? 5'd1 : 5'd0;
    localparam logic [4:0] LAST_IDX  = 5'd31;

    state_t     state;
    logic [4:0] cur;
    logic       mode;
    logic [4:0] start_idx;
    logic [4:0] next_idx;

    // Index of the first register to read for a newly accepted request.
    assign start_idx = dump_all ? FIRST_IDX : addr;
    assign next_idx  = cur + 5'd1;

    // Single state machine; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cur       <= 5'd0;
            mode      <= 1'b0;
            rf_sel    <= 5'd0;
            out_valid <= 1'b0;
            out_addr  <= 5'd0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort in IDLE suppresses a same-cycle start
                    if (start && !abort) begin
                        mode   <= dump_all;
                        cur    <= start_idx;
                        rf_sel <= start_idx;
                        busy   <= 1'b1;
                        state  <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        // mux output has settled for a full cycle on rf_sel = cur
                        out_data  <= rf_data;
                        out_addr  <= cur;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!mode || cur == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cur    <= next_idx;
                            rf_sel <= next_idx;
                            state  <= S_SEL;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
